// File: rtl/pixel_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pixel_seq_pkg
//  Purpose  : Shared types and constants for the pixel-array sequencer.
//             - state_t : sequencer FSM states
//             - phase_t : strobe phase that precedes the current GAP
//             - default phase lengths (erase/expose/convert/read)
//  Revision : 1.0 - initial release
// ============================================================================
package pixel_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ERASE   = 3'd1,
        S_EXPOSE  = 3'd2,
        S_CONVERT = 3'd3,
        S_READ    = 3'd4,
        S_GAP     = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        PH_ERASE   = 2'd0,
        PH_EXPOSE  = 2'd1,
        PH_CONVERT = 2'd2,
        PH_READ    = 2'd3
    } phase_t;

    localparam logic [7:0] c_DEF_ERASE_LEN   = 8'd5;
    localparam logic [7:0] c_DEF_EXPOSE_LEN  = 8'd255;
    localparam logic [7:0] c_DEF_CONVERT_LEN = 8'd255;
    localparam logic [7:0] c_DEF_READ_LEN    = 8'd5;

endpackage : pixel_seq_pkg
`default_nettype wire

// File: rtl/pixel_phase_timer.sv
`default_nettype none
// ============================================================================
//  Module   : pixel_phase_timer
//  Purpose  : Loadable down-counter timing one strobe phase. Loading len
//             makes the phase last max(len,1) cycles; the count clamps at 0.
//  Ports    : clk    - system clock
//             reset  - asynchronous active-low reset
//             load   - load counter with len-1 (0 when len is 0)
//             len    - phase length in cycles
//             last   - high during the final cycle of the phase
//  Revision : 1.0 - initial release
// ============================================================================
module pixel_phase_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] len,
    output logic             last
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (load) begin
            // A zero length behaves as one cycle, so it also loads 0.
            r_cnt <= (len == '0) ? '0 : len - CNT_W'(1);
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign last = (r_cnt == '0);

endmodule : pixel_phase_timer
`default_nettype wire

// File: rtl/pixel_sensor_seq.sv
`default_nettype none
// ============================================================================
//  Module   : pixel_sensor_seq
//  Purpose  : Pixel-array frame sequencer: ERASE -> EXPOSE -> CONVERT ->
//             READ x N_ROWS, with a one-cycle all-low GAP after every phase.
//             Start/busy/done handshake, continuous mode and abort.
//  Ports    : clk, reset (async active-low)
//             start, continuous, abort            - control
//             erase_len/expose_len/convert_len/read_len - phase lengths
//             erase, expose, convert, read        - registered strobes
//             row_sel                             - row index during READ
//             busy, frame_done                    - status
//             frame_cnt [15:0]                    - completed frame count
//                                 (only with PIXEL_SEQ_FRAME_CNT_EN defined)
//  Revision : 1.0 - initial release
// ============================================================================
module pixel_sensor_seq
    import pixel_seq_pkg::*;
#(
    parameter int CNT_W  = 8,
    parameter int N_ROWS = 4,
    parameter int ROW_W  = (N_ROWS > 1) ? $clog2(N_ROWS) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             continuous,
    input  logic             abort,
    input  logic [CNT_W-1:0] erase_len,
    input  logic [CNT_W-1:0] expose_len,
    input  logic [CNT_W-1:0] convert_len,
    input  logic [CNT_W-1:0] read_len,
    output logic             erase,
    output logic             expose,
    output logic             convert,
    output logic             read,
    output logic [ROW_W-1:0] row_sel,
    output logic             busy,
    output logic             frame_done
`ifdef PIXEL_SEQ_FRAME_CNT_EN
    ,
    output logic [15:0]      frame_cnt
`endif
);

    localparam logic [ROW_W-1:0] c_LAST_ROW = ROW_W'(N_ROWS - 1);

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    state_t           r_state;
    phase_t           r_prev;
    logic [ROW_W-1:0] r_row;
    logic [CNT_W-1:0] r_expose_len;
    logic [CNT_W-1:0] r_convert_len;
    logic [CNT_W-1:0] r_read_len;
    logic             r_erase;
    logic             r_expose;
    logic             r_convert;
    logic             r_read;
    logic             r_busy;
    logic             r_frame_done;

    // ------------------------------------------------------------------
    // Next-state decode
    // ------------------------------------------------------------------
    state_t           w_next;
    phase_t           w_prev_next;
    logic [ROW_W-1:0] w_row_next;
    logic             w_load;
    logic [CNT_W-1:0] w_len;
    logic             w_frame_start;
    logic             w_frame_done;
    logic             w_last;

    always_comb begin
        w_next        = r_state;
        w_prev_next   = r_prev;
        w_row_next    = r_row;
        w_load        = 1'b0;
        w_len         = erase_len;
        w_frame_start = 1'b0;
        w_frame_done  = 1'b0;

        if (abort && (r_state != S_IDLE)) begin
            w_next     = S_IDLE;
            w_row_next = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start && !abort) begin
                        w_next        = S_ERASE;
                        w_load        = 1'b1;
                        w_len         = erase_len;
                        w_frame_start = 1'b1;
                        w_row_next    = '0;
                    end
                end
                S_ERASE: begin
                    if (w_last) begin
                        w_next      = S_GAP;
                        w_prev_next = PH_ERASE;
                    end
                end
                S_EXPOSE: begin
                    if (w_last) begin
                        w_next      = S_GAP;
                        w_prev_next = PH_EXPOSE;
                    end
                end
                S_CONVERT: begin
                    if (w_last) begin
                        w_next      = S_GAP;
                        w_prev_next = PH_CONVERT;
                    end
                end
                S_READ: begin
                    if (w_last) begin
                        w_next       = S_GAP;
                        w_prev_next  = PH_READ;
                        // The GAP after the final row is the done cycle.
                        w_frame_done = (r_row == c_LAST_ROW);
                    end
                end
                S_GAP: begin
                    case (r_prev)
                        PH_ERASE: begin
                            w_next = S_EXPOSE;
                            w_load = 1'b1;
                            w_len  = r_expose_len;
                        end
                        PH_EXPOSE: begin
                            w_next = S_CONVERT;
                            w_load = 1'b1;
                            w_len  = r_convert_len;
                        end
                        PH_CONVERT: begin
                            w_next     = S_READ;
                            w_load     = 1'b1;
                            w_len      = r_read_len;
                            w_row_next = '0;
                        end
                        default: begin // PH_READ
                            if (r_row == c_LAST_ROW) begin
                                w_row_next = '0;
                                if (continuous) begin
                                    w_next        = S_ERASE;
                                    w_load        = 1'b1;
                                    w_len         = erase_len;
                                    w_frame_start = 1'b1;
                                end else begin
                                    w_next = S_IDLE;
                                end
                            end else begin
                                // Only reached below the last row, so the
                                // row index saturates at c_LAST_ROW.
                                w_next     = S_READ;
                                w_load     = 1'b1;
                                w_len      = r_read_len;
                                w_row_next = r_row + ROW_W'(1);
                            end
                        end
                    endcase
                end
                default: begin
                    w_next     = S_IDLE;
                    w_row_next = '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Phase timer
    // ------------------------------------------------------------------
    pixel_phase_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .load  (w_load),
        .len   (w_len),
        .last  (w_last)
    );

    // ------------------------------------------------------------------
    // State and registered outputs (decoded from next state)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_prev        <= PH_ERASE;
            r_row         <= '0;
            r_expose_len  <= '0;
            r_convert_len <= '0;
            r_read_len    <= '0;
            r_erase       <= 1'b0;
            r_expose      <= 1'b0;
            r_convert     <= 1'b0;
            r_read        <= 1'b0;
            r_busy        <= 1'b0;
            r_frame_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_prev  <= w_prev_next;
            r_row   <= w_row_next;
            // The erase length is consumed directly by the timer load at
            // frame start; the remaining lengths are held for the frame.
            if (w_frame_start) begin
                r_expose_len  <= expose_len;
                r_convert_len <= convert_len;
                r_read_len    <= read_len;
            end
            r_erase      <= (w_next == S_ERASE);
            r_expose     <= (w_next == S_EXPOSE);
            r_convert    <= (w_next == S_CONVERT);
            r_read       <= (w_next == S_READ);
            r_busy       <= (w_next != S_IDLE);
            r_frame_done <= w_frame_done;
        end
    end

    assign erase      = r_erase;
    assign expose     = r_expose;
    assign convert    = r_convert;
    assign read       = r_read;
    assign row_sel    = r_row;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;

`ifdef PIXEL_SEQ_FRAME_CNT_EN
    // Counts completed frames; advances together with frame_done and
    // wraps naturally at 16 bits. Abort does not touch it.
    logic [15:0] r_frame_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_frame_cnt <= '0;
        end else if (w_frame_done && !(abort && (r_state != S_IDLE))) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

    assign frame_cnt = r_frame_cnt;
`else
    // No frame counter in this build.
`endif

endmodule : pixel_sensor_seq
`default_nettype wire

// File: tb/tb_pixel_sensor_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pixel_sensor_seq
//  Purpose  : Scoreboard testbench for pixel_sensor_seq. Stimulus pushes the
//             expected strobe pulses / frame_done events; a monitor measures
//             each pulse and pops the scoreboard to compare.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pixel_sensor_seq;
    import pixel_seq_pkg::*;

    localparam int K_ERASE = 0, K_EXPOSE = 1, K_CONVERT = 2, K_READ = 3, K_FD = 4;

    typedef struct {
        int kind;
        int len;
        int row;
    } ev_t;

    logic       clk;
    logic       reset;
    logic       start;
    logic       continuous;
    logic       abort;
    logic [7:0] erase_len, expose_len, convert_len, read_len;
    logic       erase, expose, convert, read;
    logic [1:0] row_sel;
    logic       busy, frame_done;
`ifdef PIXEL_SEQ_FRAME_CNT_EN
    logic [15:0] frame_cnt;
`endif

    int  n_cmp = 0;
    int  n_bad = 0;
    ev_t sb[$];

    pixel_sensor_seq #(.CNT_W(8), .N_ROWS(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .continuous  (continuous),
        .abort       (abort),
        .erase_len   (erase_len),
        .expose_len  (expose_len),
        .convert_len (convert_len),
        .read_len    (read_len),
        .erase       (erase),
        .expose      (expose),
        .convert     (convert),
        .read        (read),
        .row_sel     (row_sel),
        .busy        (busy),
        .frame_done  (frame_done)
`ifdef PIXEL_SEQ_FRAME_CNT_EN
        ,
        .frame_cnt   (frame_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog timeout compared=%0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic push(input int kind, input int len, input int row);
        ev_t e;
        e.kind = kind; e.len = len; e.row = row;
        sb.push_back(e);
    endtask

    function automatic int eff(input int l);
        return (l == 0) ? 1 : l;
    endfunction

    // Expected events for one complete 4-row frame.
    task automatic push_frame(input int e, input int x, input int c, input int r);
        push(K_ERASE, eff(e), 0);
        push(K_EXPOSE, eff(x), 0);
        push(K_CONVERT, eff(c), 0);
        for (int i = 0; i < 4; i++) push(K_READ, eff(r), i);
        push(K_FD, eff(e) + eff(x) + eff(c) + 4 * eff(r) + 7, 1);
    endtask

    function automatic bit sig(input int which);
        case (which)
            0: return erase;
            1: return expose;
            2: return convert;
            3: return read;
            4: return frame_done;
            5: return read && (row_sel == 2'd2);
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_for(input int which, input int budget);
        int n = 0;
        while (!sig(which) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!sig(which)) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_timeout sig=%0d actual=0 required=1", which);
        end
    endtask

    function automatic int outs();
        return {erase, expose, convert, read, busy, frame_done, row_sel};
    endfunction

    task automatic set_len(input int e, input int x, input int c, input int r);
        erase_len = 8'(e); expose_len = 8'(x); convert_len = 8'(c); read_len = 8'(r);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Monitor: measures strobe pulses and frame_done, compares to scoreboard
    // ------------------------------------------------------------------
    logic [3:0] prev_s = 4'b0;
    int         run_len[4];
    int         run_row = 0;
    bit         row_chg = 1'b0;
    int         frame_len = 0;

    task automatic compare_ev(input ev_t o);
        ev_t x;
        n_cmp++;
        if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_event kind=%0d len=%0d row=%0d required=none", o.kind, o.len, o.row);
        end else begin
            x = sb.pop_front();
            if (x.kind != o.kind || x.len != o.len || x.row != o.row) begin
                n_bad++;
                $display("FAIL event actual kind=%0d len=%0d row=%0d required kind=%0d len=%0d row=%0d",
                         o.kind, o.len, o.row, x.kind, x.len, x.row);
            end
        end
    endtask

    always @(negedge clk) begin
        logic [3:0] cur;
        ev_t        o;
        cur = {read, convert, expose, erase};
        for (int k = 0; k < 4; k++) begin
            if (prev_s[k] && !cur[k]) begin
                o.kind = k;
                o.len  = run_len[k];
                o.row  = (k == K_READ) ? (row_chg ? -1 : run_row) : 0;
                compare_ev(o);
            end
        end
        for (int k = 0; k < 4; k++) begin
            if (cur[k] && !prev_s[k]) begin
                // The previous cycle must have had every strobe low.
                check("gap_before_strobe", int'(prev_s), 0);
                run_len[k] = 1;
                if (k == K_READ) begin
                    run_row = int'(row_sel);
                    row_chg = 1'b0;
                end
            end else if (cur[k]) begin
                run_len[k]++;
                if (k == K_READ && int'(row_sel) != run_row) row_chg = 1'b1;
            end
        end
        if (erase && !prev_s[0]) frame_len = 1;
        else frame_len++;
        if (frame_done) begin
            o.kind = K_FD;
            o.len  = frame_len;
            o.row  = int'(busy);
            compare_ev(o);
        end
        prev_s = cur;
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        reset = 1'b0; start = 1'b0; continuous = 1'b0; abort = 1'b0;
        set_len(0, 0, 0, 0);
        repeat (3) @(negedge clk);
        check("reset_outputs", outs(), 0);
        reset = 1'b1;

        // 1: idle after reset, no start
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_outputs", outs(), 0);
        end

        // 2: default lengths, start pulse; extra start during CONVERT ignored
        set_len(int'(c_DEF_ERASE_LEN), int'(c_DEF_EXPOSE_LEN),
                int'(c_DEF_CONVERT_LEN), int'(c_DEF_READ_LEN));
        push_frame(5, 255, 255, 5);
        pulse_start();
        check("erase_after_start", {erase, busy}, 2'b11);
        wait_for(2, 1000);
        pulse_start();
        wait_for(4, 2000);
        @(negedge clk);
        check("busy_after_frame", {busy, erase}, 0);

        // 3: all zero lengths -> 14-cycle frame
        set_len(0, 0, 0, 0);
        push_frame(0, 0, 0, 0);
        pulse_start();
        wait_for(4, 100);
        @(negedge clk);
        check("busy_after_zero_frame", busy, 0);
`ifdef PIXEL_SEQ_FRAME_CNT_EN
        check("frame_cnt_two", frame_cnt, 2);
`endif

        // 5: abort at expose cycle 100, restart 3 cycles later
        set_len(5, 255, 255, 5);
        push(K_ERASE, 5, 0);
        push(K_EXPOSE, 100, 0);
        pulse_start();
        wait_for(1, 100);
        repeat (99) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_outputs", outs(), 0);
`ifdef PIXEL_SEQ_FRAME_CNT_EN
        check("frame_cnt_after_abort", frame_cnt, 2);
`endif
        repeat (2) @(negedge clk);
        set_len(3, 4, 5, 1);
        push_frame(3, 4, 5, 1);
        pulse_start();
        wait_for(4, 200);
        @(negedge clk);
        check("busy_after_restart_frame", busy, 0);

        // 4: continuous, lengths changed mid-frame apply to frame two only
        set_len(2, 3, 4, 2);
        continuous = 1'b1;
        push_frame(2, 3, 4, 2);
        push_frame(1, 2, 1, 3);
        pulse_start();
        wait_for(1, 100);
        set_len(1, 2, 1, 3);
        wait_for(4, 200);
        @(negedge clk);
        check("continuous_restart", {erase, busy, row_sel}, 4'b1100);
        continuous = 1'b0;
        wait_for(4, 200);
        @(negedge clk);
        check("busy_after_continuous", busy, 0);

        // 6: async reset during READ row 2
        set_len(1, 1, 1, 2);
        push(K_ERASE, 1, 0);
        push(K_EXPOSE, 1, 0);
        push(K_CONVERT, 1, 0);
        push(K_READ, 2, 0);
        push(K_READ, 2, 1);
        push(K_READ, 1, 2);
        pulse_start();
        wait_for(5, 200);
        #2;
        reset = 1'b0;
        #1;
        check("async_reset_outputs", outs(), 0);
`ifdef PIXEL_SEQ_FRAME_CNT_EN
        check("frame_cnt_reset", frame_cnt, 0);
`endif
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_after_reset", outs(), 0);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_pixel_sensor_seq
`default_nettype wire

// File: doc/pixel_sensor_seq.md
Name: pixel_sensor_seq

Overview:
Parametrised pixel-array sequencer, next generation of the single-pixel erase/expose/convert/read controller.
- Sequences one frame as ERASE → EXPOSE → CONVERT → READ, with READ repeated once per row.
- Phase lengths are runtime-programmable.
- Supports start/busy/done handshake, single-shot or continuous operation, and abort.
- Sits between the top-level control/register interface and the pixel array plus ADC ramp logic.

Parameters:
- CNT_W, 8: width of phase-length inputs and internal phase counter.
- N_ROWS, 4: rows read per frame (≥1).
- ROW_W, $clog2(N_ROWS) (min 1): width of row_sel.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset; reset=0 forces reset state immediately.
- start  in  1  request one frame; sampled only in IDLE.
- continuous  in  1  1 = restart automatically after each frame; sampled at frame end.
- abort  in  1  terminate current frame; returns to IDLE next cycle.
- erase_len  in  CNT_W  erase phase length in cycles.
- expose_len  in  CNT_W  expose phase length in cycles.
- convert_len  in  CNT_W  convert phase length in cycles.
- read_len  in  CNT_W  per-row read length in cycles.
- erase  out  1  pixel erase strobe.
- expose  out  1  pixel expose strobe.
- convert  out  1  ADC convert strobe.
- read  out  1  row read strobe.
- row_sel  out  ROW_W  active row index during READ; 0 otherwise.
- busy  out  1  frame in progress.
- frame_done  out  1  one-cycle pulse at completion of a frame.

Behaviour:
- Reset values: all outputs 0; state IDLE; counters 0.
- All outputs are registered on rising clk, decoded from next state. No negedge logic.
- States: IDLE, ERASE, EXPOSE, CONVERT, READ, GAP (enum in package).
- Length latching: all *_len inputs are latched when a frame starts (start accepted or continuous restart). Mid-frame input changes have no effect.
- Zero length: a latched length of 0 is treated as 1.
- Phase length: a strobe is high for exactly len consecutive cycles.
- GAP: exactly one cycle with all strobes low, inserted after ERASE, after EXPOSE, after CONVERT, and after every row's READ. Strobes never overlap or abut.
- Start: in IDLE with start=1 and abort=0, erase and busy are asserted the next cycle. start while busy is ignored.
- READ sequencing:
  - Rows are read in order 0..N_ROWS-1.
  - row_sel holds the current row for the whole READ phase and its following GAP.
  - row_sel increments on entry to the next row's READ.
- Frame end:
  - The GAP after row N_ROWS-1 asserts frame_done for 1 cycle with busy still 1.
  - Next cycle: if continuous=1 (sampled in that GAP), go to ERASE with busy=1 and row_sel=0. Otherwise go to IDLE with busy=0.
- Frame length: E+X+C+N_ROWS·R+(3+N_ROWS) cycles, from first erase cycle through frame_done cycle inclusive.
- Abort: abort=1 in any non-IDLE state gives, next cycle, state IDLE, all strobes 0, busy 0, row_sel 0. No frame_done. abort has priority over start and continuous.
- Reset mid-frame: asynchronous return to reset values; no pulse is emitted.
- Counter: phase counter counts down from latched len-1 and does not wrap. Row counter saturates at N_ROWS-1.

Optional Feature:
- Macro PIXEL_SEQ_FRAME_CNT_EN.
- Defined: adds output frame_cnt [15:0].
  - Increments in the cycle frame_done is asserted; wraps 0xFFFF→0.
  - Cleared only by reset; abort does not clear it.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Package pixel_seq_pkg:
  - state enum (IDLE, ERASE, EXPOSE, CONVERT, READ, GAP).
  - phase typedef used to record which phase precedes each GAP.
  - default length constants: 5/255/255/5.
- Sub-module pixel_phase_timer:
  - loadable CNT_W down-counter with zero-clamp.
  - inputs load, len; output last (final cycle of phase).
  - instantiated once in the sequencer.

Test Plan:
1. Reset held low, then released, with start=0 → all outputs 0 and busy stays 0 for 20 cycles.
2. Lengths 5/255/255/5, N_ROWS=4, single start pulse:
   - erase high 5 cycles, expose 255, convert 255.
   - read 5 cycles per row, row_sel 0,1,2,3.
   - frame_done at cycle 542 after start acceptance; then busy=0.
3. Lengths all 0 → each strobe high exactly 1 cycle; frame = 3+4+7 = 14 cycles.
4. continuous=1 held:
   - second erase begins the cycle after the first frame_done.
   - length changes mid-frame apply only to the second frame.
5. abort at expose cycle 100 → next cycle all strobes 0, busy 0, no frame_done. A start 3 cycles later runs a full frame.
6. start pulsed during CONVERT → ignored. reset=0 during READ row 2 → outputs 0 asynchronously. With PIXEL_SEQ_FRAME_CNT_EN, frame_cnt=2 after two frames and stays 2 after an abort.
